// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port: TXDATA push into a small FIFO,
// combinational STATUS read, and a registered-output serial shifter.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);
  localparam logic [BitW-1:0] BitLast = BitW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [2:0]        bitidx_q, bitidx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic hit_data, hit_stat;
  logic push_req, push, pop;
  logic full, empty, bit_end;
  logic ovf_clr;
  logic unused_bits;

  // Address decode
  assign sel      = (daddr[31:3] == BASE_ADDR[31:3]);
  assign hit_data = (daddr == BASE_ADDR);
  assign hit_stat = (daddr == BASE_ADDR + 32'd4);
  assign push_req = hit_data & we[0];
  assign ovf_clr  = hit_stat & we[0] & dwdata[3];

  assign unused_bits = ^{we[3:1], dwdata[31:8]};

  assign full  = (count_q == Depth);
  assign empty = (count_q == '0);

  // A push while full is still accepted when the shifter pops on the same edge.
  assign push = push_req & (~full | pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dwdata[7:0];
  end

  always_comb begin
    rdata = 32'd0;
    if (hit_stat) begin
      rdata = {24'd0, 4'(count_q), ovf_q, busy, empty, full};
    end
  end

  // Shifter: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  assign bit_end = (bitcnt_q == BitLast);

  // Shifter: next-state logic
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        bitcnt_d = '0;
        bitidx_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bitcnt_d = '0;
          bitidx_d = '0;
          state_d  = StData;
        end else begin
          bitcnt_d = bitcnt_q + BitW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          bitcnt_d = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          if (bitidx_q == 3'd7) begin
            bitidx_d = '0;
            state_d  = StStop;
          end else begin
            bitidx_d = bitidx_q + 3'd1;
          end
        end else begin
          bitcnt_d = bitcnt_q + BitW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          bitcnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bitcnt_d = bitcnt_q + BitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shifter: output logic; txd is computed from next state so the register lines up with it.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      StIdle:  txd_d = 1'b1;
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      StStop:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  assign txd  = txd_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a serial monitor checks frames against a byte scoreboard,
// directed sequences check reset, status, overflow, back-to-back and decode behaviour.
module tb_mmio_uart_tx;

  localparam int unsigned Cpb = 4;
  localparam logic [31:0] Base = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  we = '0;
  logic [31:0] rdata;
  logic        sel;
  logic        txd;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  sb [$];
  logic        mon_en = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .daddr (daddr),
    .dwdata(dwdata),
    .we    (we),
    .rdata (rdata),
    .sel   (sel),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Drive one bus cycle; called at a negedge, returns at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    daddr  = a;
    dwdata = d;
    we     = w;
    @(negedge clk);
    we = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    daddr = a;
    we    = 4'b0000;
    #1;
    v = rdata;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_left"}, sb.size(), 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // Serial monitor: samples each bit near its centre and scores the data byte.
  initial begin
    logic [9:0] bits;
    forever begin
      @(negedge txd);
      if (!mon_en || !reset) continue;
      @(negedge clk);
      @(negedge clk);
      bits[0] = txd;
      for (int b = 1; b < 10; b++) begin
        repeat (Cpb) @(negedge clk);
        bits[b] = txd;
      end
      check("frame_start_bit", {31'd0, bits[0]}, 0);
      check("frame_stop_bit", {31'd0, bits[9]}, 1);
      if (sb.size() == 0) begin
        check("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
      end else begin
        check("frame_data", {24'd0, bits[8:1]}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] v;
    int busy_n;
    int f1, f2, bl;
    logic prev, cur;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_txd", {31'd0, txd}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    rd(Base + 32'd4, v);
    check("rst_status", v, 32'h2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset mid-frame with bytes queued
    wr(Base, 32'h3C, 4'b0001);
    wr(Base, 32'h11, 4'b0001);
    wr(Base, 32'h22, 4'b0001);
    wr(Base, 32'h33, 4'b0001);
    repeat (10) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 1);
    rd(Base + 32'd4, v);
    check("mid_status", v, 32'h34);
    #2;
    reset = 1'b0;
    #1;
    check("abort_txd", {31'd0, txd}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    rd(Base + 32'd4, v);
    check("abort_status", v, 32'h2);
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_txd", {31'd0, txd}, 1);
    check("post_rst_busy", {31'd0, busy}, 0);
    mon_en = 1'b1;

    // Single byte: latency and frame length
    wr(Base, 32'hA5, 4'b0001);
    sb.push_back(8'hA5);
    check("t2_txd_pre", {31'd0, txd}, 1);
    check("t2_busy_pre", {31'd0, busy}, 0);
    @(negedge clk);
    check("t2_txd_start", {31'd0, txd}, 0);
    check("t2_busy_start", {31'd0, busy}, 1);
    busy_n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_n++;
    end
    check("t2_frame_cycles", busy_n, 40);
    rd(Base + 32'd4, v);
    check("t2_status_idle", v, 32'h2);

    // Fill and overflow
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr(Base, 32'h10 + i, 4'b0001);
      if (i < 5) sb.push_back(8'(8'h10 + i));
    end
    rd(Base + 32'd4, v);
    check("t3_status_full_ovf", v, 32'h4D);
    wr(Base + 32'd4, 32'h8, 4'b0001);
    rd(Base + 32'd4, v);
    check("t3_status_ovf_clr", v, 32'h45);
    wait_drain("t3_drain", 400);
    rd(Base + 32'd4, v);
    check("t3_status_idle", v, 32'h2);

    // Back-to-back frames
    @(negedge clk);
    wr(Base, 32'h00, 4'b0001);
    sb.push_back(8'h00);
    wr(Base, 32'hFF, 4'b0001);
    sb.push_back(8'hFF);
    prev = 1'b1;
    f1 = -1;
    f2 = -1;
    bl = -1;
    for (int i = 0; i < 200; i++) begin
      cur = txd;
      if (prev && !cur) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      if (!busy && f1 >= 0 && bl < 0) bl = i;
      prev = cur;
      if (bl >= 0) break;
      @(negedge clk);
    end
    check("t4_first_start", f1, 0);
    check("t4_start_gap", f2 - f1, 40);
    check("t4_total_cycles", bl - f1, 80);
    wait_drain("t4_drain", 200);

    // Push and pop on the same edge while full
    @(negedge clk);
    wr(Base, 32'h81, 4'b0001);
    sb.push_back(8'h81);
    for (int i = 0; i < 4; i++) begin
      wr(Base, 32'h82 + i, 4'b0001);
      sb.push_back(8'(8'h82 + i));
    end
    rd(Base + 32'd4, v);
    check("t5_status_full", v, 32'h45);
    repeat (36) @(negedge clk);
    rd(Base + 32'd4, v);
    check("t5_status_pre_pop", v, 32'h45);
    wr(Base, 32'h86, 4'b0001);
    sb.push_back(8'h86);
    rd(Base + 32'd4, v);
    check("t5_status_post", v, 32'h45);
    wait_drain("t5_drain", 600);

    // Decode
    @(negedge clk);
    wr(Base, 32'h5A, 4'b1110);
    wr(Base + 32'd8, 32'h5A, 4'b1111);
    repeat (3) @(negedge clk);
    check("t6_busy", {31'd0, busy}, 0);
    rd(Base + 32'd4, v);
    check("t6_status", v, 32'h2);
    rd(Base + 32'd8, v);
    check("t6_sel_b8", {31'd0, sel}, 0);
    check("t6_rdata_b8", v, 0);
    rd(Base, v);
    check("t6_sel_b0", {31'd0, sel}, 1);
    check("t6_rdata_b0", v, 0);
    rd(Base + 32'd4, v);
    check("t6_sel_b4", {31'd0, sel}, 1);
    rd(Base - 32'd4, v);
    check("t6_sel_below", {31'd0, sel}, 0);
    repeat (60) @(negedge clk);
    check("t6_no_frame", {31'd0, txd}, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle CPU's data port, in parallel with `dmem`. It decodes `daddr`/`we` from the CPU, buffers written bytes in a small FIFO, and serialises them 8N1, LSB-first, on `txd`. Status is returned combinationally so the CPU's single-cycle load path sees it in the same cycle. The top level muxes `rdata` into `drdata` when `sel` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base. TXDATA is at +0; STATUS is at +4.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, default 4: FIFO entries; 4 or 8 only.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `daddr`  in  32: CPU data address.
- `dwdata`  in  32: CPU store data.
- `we`  in  4: CPU byte write enables.
- `rdata`  out  32: combinational read data.
- `sel`  out  1: combinational address hit, `daddr[31:3] == BASE_ADDR[31:3]`.
- `txd`  out  1: serial output; idles high.
- `busy`  out  1: shifter not IDLE.

## Operation
- **TXDATA write:** `daddr==BASE_ADDR` and `we[0]` push `dwdata[7:0]`. `we[3:1]` are ignored.
- **Overflow:** a push while full is dropped and sets sticky `ovf`.
  - Exception: a push and a pop in the same cycle while full is accepted; the count is unchanged.
- **STATUS write:** `daddr==BASE_ADDR+4`, `we[0]` and `dwdata[3]=1` clear `ovf` (write-1-to-clear). All other bits are ignored.
- **STATUS read** (`daddr==BASE_ADDR+4`):
  - bit0 = full
  - bit1 = empty
  - bit2 = busy
  - bit3 = ovf
  - bits[7:4] = FIFO count
  - all other bits 0
- **Other reads:** `rdata` = 0 for any other address, including TXDATA.
- **FIFO:** circular buffer with read/write pointers and a separate count. Pointers wrap modulo `FIFO_DEPTH`.
- **Shifter FSM:** states IDLE, START, DATA, STOP. A bit counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
  - IDLE, `txd=1`: if FIFO non-empty, pop into the shift register and go to START.
  - START, `txd=0`: after CLKS_PER_BIT cycles, go to DATA with index 0.
  - DATA, `txd=shift[0]`: every CLKS_PER_BIT cycles, shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP, `txd=1`: after CLKS_PER_BIT cycles:
    - FIFO non-empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- **`txd` is registered** (glitch-free).

## Timing
- **Reset values** (reset low, asynchronous):
  - `txd=1`, `busy=0`, state IDLE.
  - FIFO empty, pointers 0, count 0, `ovf=0`.
  - Bit counter and bit index 0.
- **Reset mid-frame:** aborts the frame; `txd` returns to 1 immediately and the FIFO contents are lost.
- **Reset release:** the first active edge is the first `clk` rising edge with `reset` high.
- **Write latency:** a write sampled at edge k makes the FIFO non-empty after k. The FSM pops at edge k+1, and `txd` falls after edge k+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles.
- **Back-to-back frames:** stop bit is followed immediately by the next start bit.
- **STATUS read timing:** reflects pre-edge state in the same cycle, with no read side effects.
- **Full flag:** count==FIFO_DEPTH. The pop-on-same-edge exception is evaluated with pre-edge state.
- **`busy`:** goes high on the edge that leaves IDLE and low on the edge that enters IDLE.

## Test plan
1. **Reset and idle:** assert reset low mid-frame → `txd=1`, `busy=0`, STATUS read = 32'h0000_0002.
2. **Single byte:** `CLKS_PER_BIT=4`; write 8'hA5 to TXDATA → `txd` low 1 cycle after the write edge. Sample at bit centres gives 0,1,0,1,0,0,1,0,1,1. Total 40 cycles, then `busy=0`.
3. **Fill and overflow:** `FIFO_DEPTH=4`; write 6 bytes on consecutive cycles → first byte popped; 4 queued, STATUS bit0=1 and bits[7:4]=4; 6th write dropped, bit3=1.
   - Write 32'h8 to STATUS → bit3=0.
4. **Back-to-back:** queue 8'h00 then 8'hFF → frames are contiguous (80 cycles, no idle between the stop bit and the second start bit). Second frame's data bits are all 1.
5. **Simultaneous push/pop at full:** make the FIFO full and arrange a push on the same edge the STOP→START pop occurs → push accepted, count stays 4, `ovf` stays 0. All bytes are transmitted in order.
6. **Decode:** write with `we=4'b1110` to TXDATA, and write to BASE+8 → no push, `sel=0` at BASE+8, `rdata=0` at BASE+0.
